filter_mode_xfade: RTL and testbench
====================================

# filter_mode_xfade

Parametrised successor to the single-bit filter type switch. It selects one of `N_MODES` signed multi-bit filter outputs (1-pole…N-pole lowpass taps) from a MIDI CC value and applies hysteresis around the zone boundaries. Every mode change is a linear crossfade over a fixed number of samples, so switching does not click. It sits between the ladder-filter pole taps and the output VCA, running on the system clock with a per-sample enable.

## Interface
- `DATA_W`, 16, signed audio sample width
- `N_MODES`, 4, number of selectable filter taps; power of two, 2..8
- `CC_W`, 7, width of the CC control value
- `HYST`, 2, hysteresis margin in CC steps around each zone boundary
- `XF_LOG2`, 6, log2 of crossfade length in samples (64)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `sample_valid`  in  1  one-cycle strobe; new sample present on `pole_in`
- `pole_in`  in  `N_MODES*DATA_W`  signed taps; tap k at bits `[k*DATA_W +: DATA_W]`
- `mode_cc`  in  `CC_W`  filter-type CC value
- `audio_out`  out  `DATA_W`  signed selected/crossfaded sample
- `out_valid`  out  1  strobe: `audio_out` updated this cycle
- `active_mode`  out  `$clog2(N_MODES)`  mode currently audible (fade source while fading)
- `busy`  out  1  crossfade in progress

## Operation
- All state advances only on cycles with `sample_valid`=1. Other cycles hold all state; `out_valid`=0.
- Zone boundaries: `B_k = k * 2^CC_W / N_MODES`, k=1..N_MODES-1. Raw zone `z = mode_cc >> (CC_W - log2 N_MODES)`.
- Target update (registered `tgt`):
  - if `z > tgt`, accept when `mode_cc >= B_z + HYST`
  - if `z < tgt`, accept when `mode_cc < B_(z+1) - HYST`
  - otherwise hold. A jump may skip zones (e.g. 0→3 directly).
- FSM states:
  - IDLE: `out = tap[cur]`. When `tgt != cur`: latch `nxt = tgt`, `g = 0`, go to FADE.
  - FADE: `out = (tap[cur]*(2^XF_LOG2 - g) + tap[nxt]*g) >>> XF_LOG2`, then `g++`. When `g` reaches `2^XF_LOG2 - 1` on a sample, go to SETTLE.
  - SETTLE (one sample): `cur = nxt`, output `tap[nxt]`. Go to IDLE. A pending `tgt != cur` starts a new fade on the next sample.
- `tgt` changing during FADE is recorded only. The fade in flight always completes; there is no mid-fade retarget.
- Arithmetic: products `DATA_W+XF_LOG2+1` bits signed; sum `DATA_W+XF_LOG2+2` bits. Arithmetic right shift, truncation toward −∞. Weights sum to `2^XF_LOG2`, so there is no overflow and no saturation logic.
- `active_mode = cur`. `busy` = 1 in FADE and SETTLE.

## Timing
- Latency: `audio_out`/`out_valid` are registered one cycle after the `sample_valid` cycle that carried the taps.
- CC-to-fade-start: `tgt` updates on sample n; the FADE weight `g=0` applies on sample n+1; the fade spans `2^XF_LOG2` samples, plus 1 SETTLE sample.
- Reset values (`rst`=0 at a clock edge): `audio_out`=0, `out_valid`=0, `busy`=0, `active_mode`=0, `cur`=`tgt`=`nxt`=0, `g`=0, FSM=IDLE.
- Reset mid-fade aborts immediately to the reset values. On the first sample after release, `tgt` is re-evaluated from `mode_cc`.
- `mode_cc` is sampled only on `sample_valid` cycles; changes between strobes are ignored.

## Structure
- Package `filter_mode_pkg`: FSM state enum (IDLE/FADE/SETTLE), `log2 N_MODES` constant function, boundary function `B(k)`.
- Sub-module `xfade_mix`: two-tap weighted mixer (inputs a, b, g; output rounded sum). It is pure arithmetic and is reused later for wet/dry.
- Top-level holds the hysteresis comparator, the FSM, the counter, and the output register.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random taps → `audio_out`=0, `busy`=0, `active_mode`=0, `out_valid`=0.
- Pass-through: `mode_cc`=10, tap0=1234, strobe → next cycle `audio_out`=1234, `out_valid`=1, `busy`=0.
- Hysteresis: from mode 0, `mode_cc`=33 → no fade. `mode_cc`=34 → `tgt`=1, fade starts. Back to 31 → held at 1. 29 → returns to 0.
- Crossfade midpoint: tap0=1000, tap1=−1000, step cc 10→40 → after 32 fade samples `audio_out`=0; after 65 samples `audio_out`=−1000, `active_mode`=1, `busy`=0.
- Retarget mid-fade: during fade 0→1 set cc=120 → fade 0→1 completes, SETTLE, then fade 1→3 starts; no sample outside [min,max] of the taps involved.
- Reset mid-fade at g=20 → next cycle outputs at reset values; with cc=40 after release, a fresh fade 0→1 starts from g=0.

Source files
------------

// File: rtl/filter_mode_pkg.sv
// Shared types and constant helpers for the filter-mode crossfader.
package filter_mode_pkg;

    // Crossfade sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FADE   = 2'd1,
        ST_SETTLE = 2'd2
    } xf_state_t;

    // log2 of a power-of-two mode count (2..16).
    function automatic int mode_bits(input int n_modes);
        int r;
        r = 0;
        for (int i = 1; i <= 4; i++) begin
            if ((1 << i) <= n_modes) r = i;
        end
        return r;
    endfunction

    // Lower CC edge of zone k: k * 2^cc_w / n_modes, with n_modes = 2^mode_w.
    function automatic int zone_bound(input int k, input int cc_w, input int mode_w);
        return k << (cc_w - mode_w);
    endfunction

endpackage

// File: rtl/xfade_mix.sv
// Two-tap linear mixer: y = (a*(2^XF_LOG2 - g) + b*g) >>> XF_LOG2.
// The weights always sum to 2^XF_LOG2, so the result stays within [min(a,b), max(a,b)]
// and never needs saturation. Shift floors toward minus infinity.
module xfade_mix #(
    parameter int DATA_W  = 16,
    parameter int XF_LOG2 = 6
) (
    input  logic signed [DATA_W-1:0]  i_a,
    input  logic signed [DATA_W-1:0]  i_b,
    input  logic        [XF_LOG2-1:0] i_g,
    output logic signed [DATA_W-1:0]  o_y
);

    localparam int PROD_W = DATA_W + XF_LOG2 + 1;
    localparam int SUM_W  = DATA_W + XF_LOG2 + 2;

    logic        [XF_LOG2:0]  w_wa;
    logic        [XF_LOG2:0]  w_wb;
    logic signed [PROD_W-1:0] w_prod_a;
    logic signed [PROD_W-1:0] w_prod_b;
    logic signed [SUM_W-1:0]  w_sum;

    // Weights are unsigned magnitudes; they are zero-extended before the signed multiply.
    assign w_wa     = {1'b1, {XF_LOG2{1'b0}}} - {1'b0, i_g};
    assign w_wb     = {1'b0, i_g};
    assign w_prod_a = PROD_W'(i_a) * signed'(PROD_W'(w_wa));
    assign w_prod_b = PROD_W'(i_b) * signed'(PROD_W'(w_wb));
    assign w_sum    = SUM_W'(w_prod_a) + SUM_W'(w_prod_b);
    assign o_y      = DATA_W'(w_sum >>> XF_LOG2);

endmodule

// File: rtl/filter_mode_xfade.sv
// Filter-tap selector driven by a CC value, with hysteresis on zone edges and a
// linear crossfade on every mode change. State only moves on sample strobes.
module filter_mode_xfade
    import filter_mode_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int N_MODES = 4,
    parameter  int CC_W    = 7,
    parameter  int HYST    = 2,
    parameter  int XF_LOG2 = 6,
    localparam int MODE_W  = mode_bits(N_MODES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [N_MODES*DATA_W-1:0]   pole_in,
    input  logic [CC_W-1:0]             mode_cc,
    output logic signed [DATA_W-1:0]    audio_out,
    output logic                        out_valid,
    output logic [MODE_W-1:0]           active_mode,
    output logic                        busy
);

    xf_state_t                 r_state;
    xf_state_t                 w_state_next;
    logic [MODE_W-1:0]         r_tgt;
    logic [MODE_W-1:0]         r_cur;
    logic [MODE_W-1:0]         r_nxt;
    logic [XF_LOG2-1:0]        r_g;
    logic signed [DATA_W-1:0]  r_out;
    logic                      r_out_valid;

    logic [MODE_W-1:0]         w_zone;
    logic [MODE_W-1:0]         w_tgt_next;
    logic [MODE_W-1:0]         w_cur_next;
    logic [MODE_W-1:0]         w_nxt_next;
    logic [XF_LOG2-1:0]        w_g_next;
    logic signed [DATA_W-1:0]  w_out_next;
    logic signed [DATA_W-1:0]  w_taps [N_MODES];
    logic signed [DATA_W-1:0]  w_mix;
    int                        w_cc_int;
    int                        w_zone_int;

    // Unpack the tap bus so taps can be indexed by mode number.
    for (genvar k = 0; k < N_MODES; k++) begin : g_taps
        assign w_taps[k] = pole_in[k*DATA_W +: DATA_W];
    end

    xfade_mix #(
        .DATA_W  (DATA_W),
        .XF_LOG2 (XF_LOG2)
    ) u_mix (
        .i_a (w_taps[r_cur]),
        .i_b (w_taps[r_nxt]),
        .i_g (r_g),
        .o_y (w_mix)
    );

    // Raw zone is the top bits of the CC value.
    assign w_zone     = mode_cc[CC_W-1 -: MODE_W];
    assign w_cc_int   = int'(mode_cc);
    assign w_zone_int = int'(w_zone);

    // Hysteresis: a zone change is accepted only once the CC is HYST steps inside it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_tgt_next = r_tgt;
        if (w_zone > r_tgt) begin
            if (w_cc_int >= zone_bound(w_zone_int, CC_W, MODE_W) + HYST) w_tgt_next = w_zone;
        end else if (w_zone < r_tgt) begin
            if (w_cc_int < zone_bound(w_zone_int + 1, CC_W, MODE_W) - HYST) w_tgt_next = w_zone;
        end
    end

    // Crossfade sequencer: next state, next datapath values and the sample to emit.
    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_nxt_next   = r_nxt;
        w_g_next     = r_g;
        w_out_next   = w_taps[r_cur];
        unique case (r_state)
            ST_IDLE: begin
                // A fresh target (including one accepted this very sample) starts a fade.
                if (w_tgt_next != r_cur) begin
                    w_nxt_next   = w_tgt_next;
                    w_g_next     = '0;
                    w_state_next = ST_FADE;
                end
            end
            ST_FADE: begin
                w_out_next = w_mix;
                w_g_next   = r_g + 1'b1;
                if (r_g == '1) w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_out_next   = w_taps[r_nxt];
                w_cur_next   = r_nxt;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; advances only on sample strobes.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (sample_valid) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_state_next;
        end
    end

    // Mode bookkeeping and fade counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tgt <= '0;
            r_cur <= '0;
            r_nxt <= '0;
            r_g   <= '0;
        end else if (sample_valid) begin
            r_tgt <= w_tgt_next;
            r_cur <= w_cur_next;
            r_nxt <= w_nxt_next;
            r_g   <= w_g_next;
        end
    end

    // Output register: one cycle after the strobe that carried the taps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= sample_valid;
            if (sample_valid) r_out <= w_out_next;
        end
    end

    assign audio_out   = r_out;
    assign out_valid   = r_out_valid;
    assign active_mode = r_cur;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_filter_mode_xfade.sv
// Scoreboard bench for filter_mode_xfade: the driver queues expected samples,
// a monitor pops and compares whenever out_valid is seen.
module tb_filter_mode_xfade;

    localparam int DATA_W  = 16;
    localparam int N_MODES = 4;
    localparam int CC_W    = 7;
    localparam int XF_LEN  = 64;

    typedef struct packed {
        logic signed [15:0] audio;
        logic               busy;
        logic [1:0]         active;
        logic [3:0]         scen;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        sample_valid = 1'b0;
    logic [N_MODES*DATA_W-1:0]   pole_in = '0;
    logic [CC_W-1:0]             mode_cc = '0;
    logic signed [DATA_W-1:0]    audio_out;
    logic                        out_valid;
    logic [1:0]                  active_mode;
    logic                        busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   taps[4];

    filter_mode_xfade dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .pole_in      (pole_in),
        .mode_cc      (mode_cc),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .active_mode  (active_mode),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic string scen_name(input logic [3:0] s);
        case (s)
            4'd1:    return "passthru";
            4'd2:    return "hyst";
            4'd3:    return "midpoint";
            4'd4:    return "retarget";
            4'd5:    return "post_reset_fade";
            default: return "other";
        endcase
    endfunction

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Floor((a*(64-g) + b*g) / 64), written with integer division.
    function automatic int mix_ref(input int a, input int b, input int g);
        int s;
        int q;
        s = a * (XF_LEN - g) + b * g;
        q = s / XF_LEN;
        if ((s % XF_LEN) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    // One sample strobe followed by an idle cycle with junk on the inputs.
    task automatic send(input int cc, input int e_audio, input bit e_busy,
                        input int e_active, input logic [3:0] scen);
        exp_t e;
        @(negedge clk);
        mode_cc      = CC_W'(cc);
        pole_in      = {16'(taps[3]), 16'(taps[2]), 16'(taps[1]), 16'(taps[0])};
        sample_valid = 1'b1;
        e.audio  = 16'(e_audio);
        e.busy   = e_busy;
        e.active = 2'(e_active);
        e.scen   = scen;
        exp_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
        mode_cc      = CC_W'($urandom_range(0, 127));
        pole_in      = {$urandom, $urandom};
    endtask

    // 64 fade samples (g = 0..63) then the SETTLE sample.
    task automatic run_fade(input int cc1, input int chg_at, input int cc2,
                            input int src, input int dst, input logic [3:0] scen);
        for (int g = 0; g < XF_LEN; g++) begin
            send((g < chg_at) ? cc1 : cc2, mix_ref(taps[src], taps[dst], g), 1'b1, src, scen);
        end
        send(cc2, taps[dst], 1'b0, dst, scen);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/audio_out"},   audio_out,   0);
        check({tag, "/out_valid"},   out_valid,   0);
        check({tag, "/busy"},        busy,        0);
        check({tag, "/active_mode"}, active_mode, 0);
    endtask

    // Monitor: every output strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({scen_name(e.scen), "/audio_out"},   audio_out,   e.audio);
                    check({scen_name(e.scen), "/busy"},        busy,        e.busy);
                    check({scen_name(e.scen), "/active_mode"}, active_mode, e.active);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations left", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for 3 cycles with random taps and strobes.
        @(negedge clk);
        sample_valid = 1'b1;
        mode_cc      = CC_W'($urandom_range(0, 127));
        pole_in      = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset");
            mode_cc = CC_W'($urandom_range(0, 127));
            pole_in = {$urandom, $urandom};
        end
        rst          = 1'b1;
        sample_valid = 1'b0;

        // Pass-through and hysteresis around B1 = 32.
        taps = '{1234, 200, 300, 400};
        send(10, 1234, 1'b0, 0, 4'd1);
        send(33, 1234, 1'b0, 0, 4'd2);      // 33 < 32+2: no change
        send(33, 1234, 1'b0, 0, 4'd2);
        send(34, 1234, 1'b1, 0, 4'd2);      // accepted, fade 0->1 armed
        run_fade(34, 5, 31, 0, 1, 4'd2);    // 31 mid-fade is not below 30
        send(31, 200, 1'b0, 1, 4'd2);       // held at 1
        send(30, 200, 1'b0, 1, 4'd2);       // 30 is not < 30
        send(29, 200, 1'b1, 1, 4'd2);       // back to 0
        run_fade(29, 0, 29, 1, 0, 4'd2);

        // Crossfade 0->1 with +/-1000: midpoint (g=32) gives 0, end gives -1000.
        taps = '{1000, -1000, 500, 3000};
        send(10, 1000, 1'b0, 0, 4'd3);
        send(40, 1000, 1'b1, 0, 4'd3);
        run_fade(40, 0, 40, 0, 1, 4'd3);

        // Retarget mid-fade: return to 0, then fade 0->1 with cc=120 arriving at g=10.
        send(40, -1000, 1'b0, 1, 4'd4);
        send(10, -1000, 1'b1, 1, 4'd4);
        run_fade(10, 0, 10, 1, 0, 4'd4);
        send(40, 1000, 1'b1, 0, 4'd4);
        run_fade(40, 10, 120, 0, 1, 4'd4);
        send(120, -1000, 1'b1, 1, 4'd4);    // pending target 3 starts a new fade
        run_fade(120, 0, 120, 1, 3, 4'd4);

        // Reset mid-fade at g=20 during a 3->1 fade.
        send(40, 3000, 1'b1, 3, 4'd4);
        for (int g = 0; g < 20; g++) begin
            send(40, mix_ref(taps[3], taps[1], g), 1'b1, 3, 4'd4);
        end
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b1;
        mode_cc      = CC_W'(100);
        @(negedge clk);
        check_reset_outputs("reset_mid_fade");
        rst          = 1'b1;
        sample_valid = 1'b0;

        // Fresh fade 0->1 from g=0 after release.
        send(40, 1000, 1'b1, 0, 4'd5);
        run_fade(40, 0, 40, 0, 1, 4'd5);

        repeat (4) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
